// File: rtl/clkdiv_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int          CNT_W       = 26;
  localparam int unsigned DEFAULT_LIM = 249_999;

  typedef logic [CNT_W-1:0] lim_t;

  // Half-period limit that turns clk_hz into a square wave at out_hz.
  function automatic int unsigned lim_for_hz(input int unsigned clk_hz,
                                             input int unsigned out_hz);
    return clk_hz / (2 * out_hz) - 1;
  endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Configuration bus for clock_divider_multi: limit write strobe and error pulse.
interface clock_divider_multi_if #(
  parameter int CNT_W = clkdiv_pkg::CNT_W
);
  logic             cfg_we;
  logic [3:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_lim;
  logic             cfg_err;

  modport master (output cfg_we, output cfg_ch, output cfg_lim, input  cfg_err);
  modport slave  (input  cfg_we, input  cfg_ch, input  cfg_lim, output cfg_err);
endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow limit, divided clock and tick.
module clkdiv_channel #(
  parameter int          CNT_W       = clkdiv_pkg::CNT_W,
  parameter int unsigned DEFAULT_LIM = clkdiv_pkg::DEFAULT_LIM
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_lim,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  logic [CNT_W-1:0] shd;

  // lim only ever reloads from the old shd (wrap or sync), so a write in the
  // same cycle lands one reload later and no half-period is cut short.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      lim     <= CNT_W'(DEFAULT_LIM);
      shd     <= CNT_W'(DEFAULT_LIM);
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (wr) shd <= wr_lim;
      if (sync) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        lim     <= shd;
      end else if (!en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (cnt == lim) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
        lim     <= shd;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: config decode, error pulse, channels.
module clock_divider_multi #(
  parameter int          NCH         = 4,
  parameter int          CNT_W       = clkdiv_pkg::CNT_W,
  parameter int unsigned DEFAULT_LIM = clkdiv_pkg::DEFAULT_LIM
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic [NCH-1:0]         en,
  input  logic                   sync,
  clock_divider_multi_if.slave   cfg,
  output logic [NCH-1:0]         clk_out,
  output logic [NCH-1:0]         tick
);

  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("clock_divider_multi: NCH must be in 1..16");
  end
  if ((DEFAULT_LIM >> CNT_W) != 0) begin : g_bad_lim
    $error("clock_divider_multi: DEFAULT_LIM does not fit in CNT_W bits");
  end

  logic [NCH-1:0] wr_vec;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) cfg.cfg_err <= 1'b0;
    else       cfg.cfg_err <= cfg.cfg_we && (int'(cfg.cfg_ch) >= NCH);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign wr_vec[c] = cfg.cfg_we && (cfg.cfg_ch == 4'(c));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_LIM (DEFAULT_LIM)
    ) u_ch (
      .clk_in  (clk_in),
      .reset   (reset),
      .en      (en[c]),
      .sync    (sync),
      .wr      (wr_vec[c]),
      .wr_lim  (cfg.cfg_lim),
      .clk_out (clk_out[c]),
      .tick    (tick[c])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi; default limit scaled to 249 (x1/1000).
module tb_clock_divider_multi;

  localparam int NCH   = 4;
  localparam int CNT_W = 26;
  localparam int DL    = 249;

  logic           clk_in = 1'b0;
  logic           reset  = 1'b1;
  logic [NCH-1:0] en     = '0;
  logic           sync   = 1'b0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  int total = 0;
  int bad   = 0;

  clock_divider_multi_if #(.CNT_W(CNT_W)) cfg_bus ();

  clock_divider_multi #(
    .NCH         (NCH),
    .CNT_W       (CNT_W),
    .DEFAULT_LIM (DL)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .cfg     (cfg_bus.slave),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] ch, input logic [CNT_W-1:0] lim);
    cfg_bus.cfg_we  = 1'b1;
    cfg_bus.cfg_ch  = ch;
    cfg_bus.cfg_lim = lim;
  endtask

  initial begin
    cfg_bus.cfg_we  = 1'b0;
    cfg_bus.cfg_ch  = '0;
    cfg_bus.cfg_lim = '0;

    chk("pkg_lim_for_hz", clkdiv_pkg::lim_for_hz(50_000_000, 100), 32'd249_999);

    #3;
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_cfg_err", 32'(cfg_bus.cfg_err), 32'h0);

    // Defaults: edge numbers below are counted from the enable.
    @(posedge clk_in); @(posedge clk_in); #1;
    reset = 1'b0;
    en    = 4'b0001;
    cyc(249); chk("def_e249_clk", 32'(clk_out), 32'h0);
    cyc(1);   chk("def_e250_clk", 32'(clk_out), 32'h1);
              chk("def_e250_tick", 32'(tick), 32'h1);
    cyc(1);   chk("def_e251_tick", 32'(tick), 32'h0);
    cyc(248); chk("def_e499_clk", 32'(clk_out), 32'h1);
    cyc(1);   chk("def_e500_clk", 32'(clk_out), 32'h0);
              chk("def_e500_tick", 32'(tick), 32'h0);
    cyc(250); chk("def_e750_clk", 32'(clk_out), 32'h1);
              chk("def_e750_tick", 32'(tick), 32'h1);

    // Safe reprogram at cnt=100: current half-period completes, then period 20.
    cyc(100); wr(4'd0, 26'd9);
    cyc(1);   cfg_bus.cfg_we = 1'b0;
              chk("rep_cfg_err_valid", 32'(cfg_bus.cfg_err), 32'h0);
    cyc(148); chk("rep_e999_clk", 32'(clk_out), 32'h1);
    cyc(1);   chk("rep_e1000_clk", 32'(clk_out), 32'h0);
    cyc(9);   chk("rep_e1009_clk", 32'(clk_out), 32'h0);
    cyc(1);   chk("rep_e1010_clk", 32'(clk_out), 32'h1);
              chk("rep_e1010_tick", 32'(tick), 32'h1);
    cyc(9);   chk("rep_e1019_clk", 32'(clk_out), 32'h1);
    cyc(1);   chk("rep_e1020_clk", 32'(clk_out), 32'h0);
    cyc(10);  chk("rep_e1030_clk", 32'(clk_out), 32'h1);

    // Write lands in the wrap cycle: old limit serves one more half-period.
    cyc(9);   wr(4'd0, 26'd3);
    cyc(1);   cfg_bus.cfg_we = 1'b0;
              chk("col_e1040_clk", 32'(clk_out), 32'h0);
    cyc(9);   chk("col_e1049_clk", 32'(clk_out), 32'h0);
    cyc(1);   chk("col_e1050_clk", 32'(clk_out), 32'h1);
    cyc(3);   chk("col_e1053_clk", 32'(clk_out), 32'h1);
    cyc(1);   chk("col_e1054_clk", 32'(clk_out), 32'h0);

    // Out-of-range channel: error pulse, nothing written.
    wr(4'd7, 26'd0);
    cyc(1);   cfg_bus.cfg_we = 1'b0;
              chk("err_pulse_hi", 32'(cfg_bus.cfg_err), 32'h1);
    cyc(1);   chk("err_pulse_lo", 32'(cfg_bus.cfg_err), 32'h0);
    cyc(2);   chk("err_ch0_unchanged", 32'(clk_out), 32'h1);

    // Minimum limit on ch1.
    wr(4'd1, 26'd0);
    cyc(1);   cfg_bus.cfg_we = 1'b0; sync = 1'b1;
    cyc(1);   sync = 1'b0; en = 4'b0010;
              chk("min_sync_clk", 32'(clk_out), 32'h0);
    cyc(1);   chk("min_c1_clk", 32'(clk_out), 32'h2);
              chk("min_c1_tick", 32'(tick), 32'h2);
    cyc(1);   chk("min_c2_clk", 32'(clk_out), 32'h0);
              chk("min_c2_tick", 32'(tick), 32'h0);
    cyc(1);   chk("min_c3_clk", 32'(clk_out), 32'h2);
              chk("min_c3_tick", 32'(tick), 32'h2);
    cyc(1);   chk("min_c4_clk", 32'(clk_out), 32'h0);

    // Phase alignment; ch3 must still hold the default limit (rejected write).
    en = 4'b1011; wr(4'd0, 26'd4);
    cyc(1);   wr(4'd1, 26'd14);
    cyc(1);   cfg_bus.cfg_we = 1'b0; sync = 1'b1;
    cyc(1);   sync = 1'b0;
              chk("ph_sync_clk", 32'(clk_out), 32'h0);
              chk("ph_sync_tick", 32'(tick), 32'h0);
    cyc(4);   chk("ph_e4_clk", 32'(clk_out), 32'h0);
    cyc(1);   chk("ph_e5_clk", 32'(clk_out), 32'h1);
              chk("ph_e5_tick", 32'(tick), 32'h1);
    cyc(5);   chk("ph_e10_clk", 32'(clk_out), 32'h0);
    cyc(5);   chk("ph_e15_clk", 32'(clk_out), 32'h3);
              chk("ph_e15_tick", 32'(tick), 32'h3);
    cyc(5);   chk("ph_e20_clk", 32'(clk_out), 32'h2);
    cyc(5);   chk("ph_e25_clk", 32'(clk_out), 32'h3);
              chk("ph_e25_tick", 32'(tick), 32'h1);

    // Async reset between edges, then defaults restored on ch0/ch1.
    #2 reset = 1'b1;
    #1;
    chk("arst_clk_out", 32'(clk_out), 32'h0);
    chk("arst_tick", 32'(tick), 32'h0);
    en = '0;
    @(posedge clk_in); #1;
    reset = 1'b0;
    en    = 4'b0011;
    cyc(249); chk("post_e249_clk", 32'(clk_out), 32'h0);
    cyc(1);   chk("post_e250_clk", 32'(clk_out), 32'h3);
              chk("post_e250_tick", 32'(tick), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
